// File: rtl/rv32i_types.sv
// Shared types and constants for the memory-side arbitration path.
//   CACHELINE_W / BMEM_BEAT_W / BEATS_PER_LINE : line and burst geometry
//   arb_state_t : bmem_arbiter FSM states
//   arb_req_t   : which cache owns the current transaction
//   line_align  : clears the byte-in-line offset of an address
package rv32i_types;

    localparam int CACHELINE_W    = 256;
    localparam int BMEM_BEAT_W    = 64;
    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_IDX_W     = 2;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_BEAT = 3'd3,
        RESP    = 3'd4
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/burst_deserializer.sv
// Assembles four 64-bit read beats into one 256-bit line.
//   clk, rst      : clock, synchronous active-low reset
//   clear         : restart assembly at beat 0 (asserted when a new transaction is granted)
//   beat_valid    : a beat belonging to the current line is present
//   beat_data     : that beat's data
//   line          : assembled line, beat k at [64k+63:64k]
//   done          : high in the cycle the final beat is being captured
module burst_deserializer
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   beat_valid,
    input  logic [BMEM_BEAT_W-1:0] beat_data,
    output logic [CACHELINE_W-1:0] line,
    output logic                   done
);

    logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = '0;
        end else if (beat_valid) begin
            // wraps to 0 after the last beat, so the next line starts clean
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // done is combinational so the FSM can leave RD_WAIT on the same edge
    // that stores the last beat, giving a one-cycle beat-to-resp latency.
    assign done = beat_valid && (beat_cnt_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_beat
            logic [BMEM_BEAT_W-1:0] beat_q, beat_d;

            always_comb begin
                beat_d = beat_q;
                if (clear) begin
                    beat_d = '0;
                end else if (beat_valid && (beat_cnt_q == BEAT_IDX_W'(gi))) begin
                    beat_d = beat_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    beat_q <= '0;
                end else begin
                    beat_q <= beat_d;
                end
            end

            assign line[gi*BMEM_BEAT_W +: BMEM_BEAT_W] = beat_q;
        end
    endgenerate

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates icache and dcache line requests onto the single burst memory port.
// One transaction at a time; line writes leave as four 64-bit beats, line reads
// come back as four tagged 64-bit beats that are reassembled into a line.
//   clk, rst                       : clock, synchronous active-low reset
//   i_dfp_addr/read                : icache line-read request (held until i_dfp_resp)
//   i_dfp_rdata/resp               : icache returned line and one-cycle completion pulse
//   d_dfp_addr/read/write/wdata    : dcache line read or writeback request (held until d_dfp_resp)
//   d_dfp_rdata/resp               : dcache returned line (zero for writebacks) and completion pulse
//   bmem_addr/read/write/wdata     : memory command / write beat, line-aligned address
//   bmem_ready                     : memory accepts the command or beat this cycle
//   bmem_raddr/rdata/rvalid        : tagged read beat return
module bmem_arbiter
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic [31:0]            i_dfp_addr,
    input  logic                   i_dfp_read,
    output logic [CACHELINE_W-1:0] i_dfp_rdata,
    output logic                   i_dfp_resp,

    input  logic [31:0]            d_dfp_addr,
    input  logic                   d_dfp_read,
    input  logic                   d_dfp_write,
    input  logic [CACHELINE_W-1:0] d_dfp_wdata,
    output logic [CACHELINE_W-1:0] d_dfp_rdata,
    output logic                   d_dfp_resp,

    output logic [31:0]            bmem_addr,
    output logic                   bmem_read,
    output logic                   bmem_write,
    output logic [BMEM_BEAT_W-1:0] bmem_wdata,
    input  logic                   bmem_ready,
    input  logic [31:0]            bmem_raddr,
    input  logic [BMEM_BEAT_W-1:0] bmem_rdata,
    input  logic                   bmem_rvalid
);

    arb_state_t            state_q, state_d;
    arb_req_t              owner_q, owner_d;
    arb_req_t              last_grant_q, last_grant_d;
    logic [31:0]           addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic [BEAT_IDX_W-1:0] wr_cnt_q, wr_cnt_d;

    logic                   d_req;
    logic                   d_wins;
    logic                   grant;
    logic                   beat_match;
    logic                   rd_done;
    logic [CACHELINE_W-1:0] rd_line;

    assign d_req = d_dfp_read | d_dfp_write;
    // dcache normally wins, but yields once after its own grant if icache is waiting
    assign d_wins = d_req && !((last_grant_q == REQ_D) && i_dfp_read);
    assign grant  = (state_q == IDLE) && (d_req || i_dfp_read);

    // Only beats tagged with the in-flight line are taken; everything else on
    // the return bus (other lines, beats outside RD_WAIT) is dropped.
    assign beat_match = (state_q == RD_WAIT) && bmem_rvalid &&
                        (line_align(bmem_raddr) == addr_q);

    burst_deserializer u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear      (grant),
        .beat_valid (beat_match),
        .beat_data  (bmem_rdata),
        .line       (rd_line),
        .done       (rd_done)
    );

    // Writeback line split into beats for the serializer mux
    logic [BMEM_BEAT_W-1:0] wr_beat [BEATS_PER_LINE];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_wr_beat
            assign wr_beat[gi] = d_dfp_wdata[gi*BMEM_BEAT_W +: BMEM_BEAT_W];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        is_wr_d      = is_wr_q;
        wr_cnt_d     = wr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d      = d_wins ? REQ_D : REQ_I;
                    last_grant_d = d_wins ? REQ_D : REQ_I;
                    addr_d       = line_align(d_wins ? d_dfp_addr : i_dfp_addr);
                    is_wr_d      = d_wins && d_dfp_write;
                    wr_cnt_d     = '0;
                    state_d      = (d_wins && d_dfp_write) ? WR_BEAT : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d = RESP;
                end
            end
            WR_BEAT: begin
                if (bmem_ready) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_I;
            last_grant_q <= REQ_I;
            addr_q       <= '0;
            is_wr_q      <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            is_wr_q      <= is_wr_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    // Outputs are decoded from state; the read command is only presented in a
    // cycle where memory can take it, so exactly one bmem_read pulse is issued.
    always_comb begin
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_addr   = '0;
        bmem_wdata  = '0;
        i_dfp_resp  = 1'b0;
        i_dfp_rdata = '0;
        d_dfp_resp  = 1'b0;
        d_dfp_rdata = '0;
        unique case (state_q)
            RD_REQ: begin
                if (bmem_ready) begin
                    bmem_read = 1'b1;
                    bmem_addr = addr_q;
                end
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wr_beat[wr_cnt_q];
            end
            RESP: begin
                if (owner_q == REQ_I) begin
                    i_dfp_resp  = 1'b1;
                    i_dfp_rdata = rd_line;
                end else begin
                    d_dfp_resp  = 1'b1;
                    d_dfp_rdata = is_wr_q ? '0 : rd_line;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    always #5 clk = ~clk;

    bmem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Deterministic memory contents used by the automatic responder
    function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
        return {a[31:5], 5'(k), 32'h5A5A_0000 + 32'(k)};
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_data(a, k);
        return l;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference: one outstanding job described by who
    // owns it, whether the read command went out, how many beats moved and
    // whether the completion is due.
    // ------------------------------------------------------------------
    bit           m_busy, m_who, m_wr, m_cmd, m_resp, m_last;  // who/last: 1 = dcache
    logic [31:0]  m_addr;
    int           m_beats;
    logic [255:0] m_line;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_last = 0;
        end else if (!m_busy) begin
            if ((d_dfp_read || d_dfp_write) && !(m_last && i_dfp_read)) begin
                m_busy = 1; m_who = 1; m_last = 1; m_wr = d_dfp_write;
                m_addr = {d_dfp_addr[31:5], 5'b0};
                m_cmd = 0; m_beats = 0; m_line = '0; m_resp = 0;
            end else if (i_dfp_read) begin
                m_busy = 1; m_who = 0; m_last = 0; m_wr = 0;
                m_addr = {i_dfp_addr[31:5], 5'b0};
                m_cmd = 0; m_beats = 0; m_line = '0; m_resp = 0;
            end
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
        end else if (m_wr) begin
            if (bmem_ready) begin
                m_beats++;
                if (m_beats == 4) m_resp = 1;
            end
        end else if (!m_cmd) begin
            if (bmem_ready) m_cmd = 1;
        end else if (bmem_rvalid && bmem_raddr[31:5] == m_addr[31:5]) begin
            m_line[64*m_beats +: 64] = bmem_rdata;
            m_beats++;
            if (m_beats == 4) m_resp = 1;
        end
    end

    // Observation logs (written only by the compare process)
    logic [31:0]  rq[$];        // accepted read command addresses
    logic [63:0]  wq[$];        // accepted write beats
    int           who_q[$];     // completion order, 1 = dcache
    int           n_resp_i = 0;
    int           n_resp_d = 0;
    logic [255:0] last_i, last_d;
    logic [31:0]  last_wr_addr;

    always @(negedge clk) begin
        logic         e_rd, e_wr, e_ir, e_dr;
        logic [31:0]  e_addr;
        logic [63:0]  e_wd;
        logic [255:0] e_il, e_dl;
        if (chk_en) begin
            e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0;
            e_addr = '0; e_wd = '0; e_il = '0; e_dl = '0;
            if (m_busy) begin
                if (m_resp) begin
                    if (m_who) begin e_dr = 1; e_dl = m_wr ? '0 : m_line; end
                    else       begin e_ir = 1; e_il = m_line; end
                end else if (m_wr) begin
                    e_wr = 1; e_addr = m_addr; e_wd = d_dfp_wdata[64*m_beats +: 64];
                end else if (!m_cmd && bmem_ready) begin
                    e_rd = 1; e_addr = m_addr;
                end
            end
            chk("bmem_cmd", {bmem_read, bmem_write, bmem_addr, bmem_wdata}, {e_rd, e_wr, e_addr, e_wd});
            chk("icache_resp", {i_dfp_resp, i_dfp_rdata}, {e_ir, e_il});
            chk("dcache_resp", {d_dfp_resp, d_dfp_rdata}, {e_dr, e_dl});

            if (bmem_read && bmem_ready) rq.push_back(bmem_addr);
            if (bmem_write && bmem_ready) begin wq.push_back(bmem_wdata); last_wr_addr = bmem_addr; end
            if (i_dfp_resp) begin
                n_resp_i++; who_q.push_back(0); last_i = i_dfp_rdata;
                $display("TXN icache read  addr=%h line=%h", i_dfp_addr, i_dfp_rdata);
            end
            if (d_dfp_resp) begin
                n_resp_d++; who_q.push_back(1); last_d = d_dfp_rdata;
                $display("TXN dcache %s addr=%h line=%h", d_dfp_write ? "write" : "read ", d_dfp_addr,
                         d_dfp_write ? d_dfp_wdata : d_dfp_rdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int rq_rd = 0;   // next read command the responder serves
    int rk    = 0;   // beat index within that command

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1; bmem_raddr = a; bmem_rdata = d;
        tick();
        bmem_rvalid = 0;
    endtask

    task automatic wait_resp(input bit d_side, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d_side ? d_dfp_resp : i_dfp_resp) begin n = k; break; end
        end
        if (n == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout side=%0d got=none want=pulse", d_side);
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 0; i_dfp_read = 0; d_dfp_read = 0; d_dfp_write = 0;
        bmem_ready = 0; bmem_rvalid = 0;
        tick(); tick();
        rst = 1;
        rq_rd = rq.size(); rk = 0;
    endtask

    // Memory model: serves accepted reads in order, sometimes stalls, sometimes
    // injects a beat for a different line, optionally sprays stray beats.
    task automatic responder_step(input bit strays);
        bmem_rvalid = 0;
        if (rq_rd < rq.size()) begin
            if ($urandom_range(3) != 0) begin
                bmem_rvalid = 1;
                if ($urandom_range(7) == 0) begin
                    bmem_raddr = rq[rq_rd] ^ 32'h0000_0100;
                    bmem_rdata = {$urandom, $urandom};
                end else begin
                    bmem_raddr = rq[rq_rd] | 32'($urandom_range(31));
                    bmem_rdata = beat_data(rq[rq_rd], rk);
                    rk++;
                    if (rk == 4) begin rk = 0; rq_rd++; end
                end
            end
        end else if (strays && $urandom_range(9) == 0) begin
            bmem_rvalid = 1; bmem_raddr = $urandom; bmem_rdata = {$urandom, $urandom};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, wbase, qbase, si, sd, rem_i, rem_d, ni0;
        logic [63:0] dw [4];
        logic [63:0] bb [4];
        int exp_who [4];

        rst = 0; i_dfp_addr = '0; i_dfp_read = 0; d_dfp_addr = '0; d_dfp_read = 0;
        d_dfp_write = 0; d_dfp_wdata = '0; bmem_ready = 0; bmem_raddr = '0;
        bmem_rdata = '0; bmem_rvalid = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 1;
        @(negedge clk);
        chk("reset_outputs", {bmem_read, bmem_write, bmem_addr, bmem_wdata, i_dfp_resp, d_dfp_resp,
                              i_dfp_rdata[31:0], d_dfp_rdata[31:0]}, '0);
        tick();

        // 1: icache read, memory always ready
        base = rq.size();
        bmem_ready = 1; i_dfp_addr = 32'h1ece_b004; i_dfp_read = 1;
        tick(); tick();
        beat(32'h1ece_b000, 64'h1111_1111_1111_1111);
        beat(32'h1ece_b000, 64'h2222_2222_2222_2222);
        beat(32'h1ece_b000, 64'h3333_3333_3333_3333);
        beat(32'h1ece_b000, 64'h4444_4444_4444_4444);
        wait_resp(0, n); i_dfp_read = 0;
        chk("t1_latency", n, 1);
        chk("t1_cmd_count", rq.size() - base, 1);
        chk("t1_cmd_addr", (rq.size() > base) ? rq[base] : 32'h0, 32'h1ece_b000);
        chk("t1_beat0", last_i[63:0], 64'h1111_1111_1111_1111);
        chk("t1_beat3", last_i[255:192], 64'h4444_4444_4444_4444);

        // 2: dcache writeback with a two-cycle stall after beat 1
        dw[0] = 64'hD0D0_0000_0000_00D0; dw[1] = 64'hD1D1_1111_1111_11D1;
        dw[2] = 64'hD2D2_2222_2222_22D2; dw[3] = 64'hD3D3_3333_3333_33D3;
        wbase = wq.size();
        d_dfp_addr = 32'h0000_1020; d_dfp_wdata = {dw[3], dw[2], dw[1], dw[0]}; d_dfp_write = 1;
        tick();                 // grant
        tick(); tick();         // beats 0 and 1 accepted
        bmem_ready = 0; tick(); tick();
        bmem_ready = 1; tick(); tick();
        wait_resp(1, n); d_dfp_write = 0;
        chk("t2_latency", n, 1);
        chk("t2_beat_count", wq.size() - wbase, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_beat%0d", k), (wq.size() > wbase + k) ? wq[wbase + k] : 64'h0, dw[k]);
        chk("t2_addr", last_wr_addr, 32'h0000_1020);
        chk("t2_rdata_zero", last_d, '0);

        // 3: both caches read continuously; completions must alternate d,i,d,i
        do_reset();
        qbase = who_q.size(); si = n_resp_i; sd = n_resp_d;
        bmem_ready = 1;
        i_dfp_addr = 32'h0000_5000; d_dfp_addr = 32'h0000_6000;
        i_dfp_read = 1; d_dfp_read = 1; rem_i = 2; rem_d = 2;
        for (int c = 0; c < 400 && (rem_i + rem_d) != 0; c++) begin
            tick();
            if (n_resp_i != si) begin
                si = n_resp_i;
                chk("t3_icache_line", last_i, exp_line(i_dfp_addr));
                rem_i--;
                if (rem_i == 0) i_dfp_read = 0; else i_dfp_addr += 32'h100;
            end
            if (n_resp_d != sd) begin
                sd = n_resp_d;
                chk("t3_dcache_line", last_d, exp_line(d_dfp_addr));
                rem_d--;
                if (rem_d == 0) d_dfp_read = 0; else d_dfp_addr += 32'h100;
            end
            responder_step(0);
        end
        bmem_rvalid = 0;
        chk("t3_all_done", rem_i + rem_d, 0);
        exp_who = '{1, 0, 1, 0};
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_grant%0d", k), (who_q.size() > qbase + k) ? who_q[qbase + k] : -1, exp_who[k]);

        // 4: foreign beats interleaved with the expected return
        tick();
        bb[0] = 64'hA0A0_0000_0000_0001; bb[1] = 64'hA1A1_0000_0000_0002;
        bb[2] = 64'hA2A2_0000_0000_0003; bb[3] = 64'hA3A3_0000_0000_0004;
        i_dfp_addr = 32'h0000_1000; i_dfp_read = 1;
        tick(); tick();
        beat(32'h0000_1000, bb[0]);
        beat(32'h0000_2000, 64'hDEAD_BEEF_DEAD_BEEF);
        beat(32'h0000_1000, bb[1]);
        beat(32'h0000_1000, bb[2]);
        beat(32'h0000_2000, 64'hBAD0_BAD0_BAD0_BAD0);
        beat(32'h0000_1000, bb[3]);
        wait_resp(0, n); i_dfp_read = 0;
        chk("t4_latency", n, 1);
        chk("t4_line", last_i, {bb[3], bb[2], bb[1], bb[0]});

        // 5: reset in RD_WAIT after two beats, late beats must not complete anything
        i_dfp_addr = 32'h0000_3000; i_dfp_read = 1;
        tick(); tick();
        beat(32'h0000_3000, 64'hC0);
        beat(32'h0000_3000, 64'hC1);
        rst = 0; i_dfp_read = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("t5_reset_outputs", {bmem_read, bmem_write, bmem_addr, bmem_wdata, i_dfp_resp, d_dfp_resp}, '0);
        tick();
        ni0 = n_resp_i;
        beat(32'h0000_3000, 64'hC2);
        beat(32'h0000_3000, 64'hC3);
        tick(); tick();
        chk("t5_no_resp", n_resp_i - ni0, 0);
        i_dfp_read = 1;
        tick(); tick();
        for (int k = 0; k < 4; k++) beat(32'h0000_3000, 64'hE0 + 64'(k));
        wait_resp(0, n); i_dfp_read = 0;
        chk("t5_after_reset_line", last_i, {64'hE3, 64'hE2, 64'hE1, 64'hE0});

        // 6: memory not ready for 5 cycles while the read command waits
        tick();
        base = rq.size();
        bmem_ready = 0; i_dfp_addr = 32'h0000_4000; i_dfp_read = 1;
        tick();
        repeat (5) tick();
        chk("t6_no_cmd_while_stalled", rq.size() - base, 0);
        bmem_ready = 1;
        tick();
        chk("t6_one_cmd", rq.size() - base, 1);
        for (int k = 0; k < 4; k++) beat(32'h0000_4000, 64'hF0 + 64'(k));
        wait_resp(0, n); i_dfp_read = 0;
        chk("t6_still_one_cmd", rq.size() - base, 1);
        chk("t6_line", last_i, {64'hF3, 64'hF2, 64'hF1, 64'hF0});

        // 7: random traffic, checked cycle by cycle against the reference
        rq_rd = rq.size(); rk = 0;
        si = n_resp_i; sd = n_resp_d;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (n_resp_i != si) begin si = n_resp_i; i_dfp_read = 0; end
            if (n_resp_d != sd) begin sd = n_resp_d; d_dfp_read = 0; d_dfp_write = 0; end
            if ($urandom_range(599) == 0) begin
                rst = 0; i_dfp_read = 0; d_dfp_read = 0; d_dfp_write = 0;
                bmem_ready = 0; bmem_rvalid = 0;
                rq_rd = rq.size(); rk = 0;
            end else begin
                rst = 1;
                if (!i_dfp_read && $urandom_range(3) == 0) begin
                    i_dfp_addr = $urandom; i_dfp_read = 1;
                end
                if (!d_dfp_read && !d_dfp_write && $urandom_range(3) == 0) begin
                    d_dfp_addr = $urandom; d_dfp_wdata = rand256();
                    if ($urandom_range(1) == 1) d_dfp_write = 1; else d_dfp_read = 1;
                end
                bmem_ready = ($urandom_range(3) != 0);
                responder_step(1);
            end
        end
        rst = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
